sample_divider: RTL and testbench

SAMPLE_DIVIDER -- requirements
Module: sample_divider

---
 rtl/sample_divider.sv | 105 ++++++++++
 tb/tb_sample_divider.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_divider.sv
// Decimating sampler: forwards one valid input in every N+1, with N held in a
// loadable divider register. Define SAMPLER_EXTCLK_EN to add external-clock sampling.
module sample_divider (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] indata,
  input  logic        dataReady,
  input  logic        wrDivider,
  input  logic [23:0] config_data,
`ifdef SAMPLER_EXTCLK_EN
  input  logic        extClock_mode,
  input  logic        extClock,
`endif
  output logic [31:0] outdata,
  output logic        sampleReady
);

  logic [23:0] divider_q,      divider_d;
  logic [23:0] counter_q,      counter_d;
  logic [31:0] outdata_q,      outdata_d;
  logic        sample_ready_q, sample_ready_d;

`ifdef SAMPLER_EXTCLK_EN
  // sync1/sync2 resynchronise extClock; edge_q holds the previous synchronised level.
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic edge_q,  edge_d;
  logic mode_q,  mode_d;
  logic ext_rise;

  assign ext_rise = sync2_q & ~edge_q;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    divider_d      = divider_q;
    counter_d      = counter_q;
    outdata_d      = outdata_q;
    sample_ready_d = 1'b0;
`ifdef SAMPLER_EXTCLK_EN
    sync1_d        = extClock;
    sync2_d        = sync1_q;
    edge_d         = sync2_q;
    mode_d         = extClock_mode;
`endif

    if (wrDivider) begin
      // A divider write restarts the division; any input on this cycle is dropped.
      divider_d = config_data;
      counter_d = '0;
    end
`ifdef SAMPLER_EXTCLK_EN
    else if (extClock_mode != mode_q) begin
      counter_d = '0;
    end else if (extClock_mode) begin
      if (ext_rise && dataReady) begin
        outdata_d      = indata;
        sample_ready_d = 1'b1;
      end
    end
`endif
    else if (dataReady) begin
      if (counter_q == '0) begin
        outdata_d      = indata;
        sample_ready_d = 1'b1;
        counter_d      = divider_q;
      end else begin
        counter_d = counter_q - 24'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      divider_q      <= '0;
      counter_q      <= '0;
      outdata_q      <= '0;
      sample_ready_q <= 1'b0;
`ifdef SAMPLER_EXTCLK_EN
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      edge_q         <= 1'b0;
      mode_q         <= 1'b0;
`endif
    end else begin
      divider_q      <= divider_d;
      counter_q      <= counter_d;
      outdata_q      <= outdata_d;
      sample_ready_q <= sample_ready_d;
`ifdef SAMPLER_EXTCLK_EN
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      edge_q         <= edge_d;
      mode_q         <= mode_d;
`endif
    end
  end

  assign outdata     = outdata_q;
  assign sampleReady = sample_ready_q;

endmodule

// File: tb/tb_sample_divider.sv
// Directed bench for sample_divider: each task drives one scenario and
// compares {sampleReady, outdata} against hand-derived values every cycle.
module tb_sample_divider;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] indata;
  logic        dataReady;
  logic        wrDivider;
  logic [23:0] config_data;
  logic [31:0] outdata;
  logic        sampleReady;
`ifdef SAMPLER_EXTCLK_EN
  logic        extClock_mode;
  logic        extClock;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  sample_divider dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .indata      (indata),
    .dataReady   (dataReady),
    .wrDivider   (wrDivider),
    .config_data (config_data),
`ifdef SAMPLER_EXTCLK_EN
    .extClock_mode (extClock_mode),
    .extClock      (extClock),
`endif
    .outdata     (outdata),
    .sampleReady (sampleReady)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are observed 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_divider(input logic [23:0] n);
    wrDivider   = 1'b1;
    config_data = n;
    dataReady   = 1'b1;
    indata      = 32'hDEAD_0000;
    tick();
    wrDivider   = 1'b0;
  endtask

  task automatic test_reset();
    logic [32:0] exp;
    reset_n = 1'b0; wrDivider = 1'b1; config_data = 24'd7;
    dataReady = 1'b1; indata = 32'hAAAA_AAAA;
    tick(); tick();
    exp = {1'b0, 32'h0};
    tests_run++;
    if ({sampleReady, outdata} !== exp) begin
      tests_failed++;
      $display("FAIL reset_state: got rdy=%b out=%h, want rdy=%b out=%h", sampleReady, outdata, exp[32], exp[31:0]);
    end
    // Divider must still be 0 after reset, so two inputs in a row are both sampled.
    reset_n = 1'b1; wrDivider = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      indata = 32'h100 + i;
      tick();
      exp = {1'b1, 32'h100 + i};
      tests_run++;
      if ({sampleReady, outdata} !== exp) begin
        tests_failed++;
        $display("FAIL reset_divider_zero[%0d]: got rdy=%b out=%h, want rdy=%b out=%h", i, sampleReady, outdata, exp[32], exp[31:0]);
      end
    end
  endtask

  task automatic test_pass_through();
    logic [32:0] exp;
    dataReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      indata = i;
      tick();
      exp = {1'b1, 32'(i)};
      tests_run++;
      if ({sampleReady, outdata} !== exp) begin
        tests_failed++;
        $display("FAIL pass_through[%0d]: got rdy=%b out=%h, want rdy=%b out=%h", i, sampleReady, outdata, exp[32], exp[31:0]);
      end
    end
  endtask

  task automatic test_divide_by_4();
    logic [32:0] exp;
    logic [31:0] held;
    held = 32'd4;
    load_divider(24'd3);
    tests_run++;
    if ({sampleReady, outdata} !== {1'b0, held}) begin
      tests_failed++;
      $display("FAIL div4_write_cycle: got rdy=%b out=%h, want rdy=0 out=%h", sampleReady, outdata, held);
    end
    // Samples expected on inputs 1, 5, 9 only.
    for (int i = 1; i <= 12; i++) begin
      indata = i;
      tick();
      if (i == 1 || i == 5 || i == 9) begin
        held = i;
        exp  = {1'b1, held};
      end else begin
        exp  = {1'b0, held};
      end
      tests_run++;
      if ({sampleReady, outdata} !== exp) begin
        tests_failed++;
        $display("FAIL div4[%0d]: got rdy=%b out=%h, want rdy=%b out=%h", i, sampleReady, outdata, exp[32], exp[31:0]);
      end
    end
  endtask

  task automatic test_gapped_valid();
    logic [32:0] exp;
    logic [31:0] held;
    held = 32'd9;
    load_divider(24'd3);
    // Valid inputs on even cycles: samples at valid inputs 0, 4 -> cycles 0, 8.
    for (int c = 0; c < 16; c++) begin
      dataReady = (c % 2 == 0);
      indata    = dataReady ? 32'd200 + c : 32'hBAD0_0000 + c;
      tick();
      if (c == 0 || c == 8) begin
        held = 32'd200 + c;
        exp  = {1'b1, held};
      end else begin
        exp  = {1'b0, held};
      end
      tests_run++;
      if ({sampleReady, outdata} !== exp) begin
        tests_failed++;
        $display("FAIL gapped[%0d]: got rdy=%b out=%h, want rdy=%b out=%h", c, sampleReady, outdata, exp[32], exp[31:0]);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [32:0] exp;
    load_divider(24'd5);
    indata = 32'h300; tick();   // sampled, counter reloads to 5
    indata = 32'h301; tick();   // counter 4
    reset_n = 1'b0; indata = 32'h302; tick();
    exp = {1'b0, 32'h0};
    tests_run++;
    if ({sampleReady, outdata} !== exp) begin
      tests_failed++;
      $display("FAIL reset_mid_count: got rdy=%b out=%h, want rdy=0 out=0", sampleReady, outdata);
    end
    reset_n = 1'b1; indata = 32'h303; tick();
    exp = {1'b1, 32'h303};
    tests_run++;
    if ({sampleReady, outdata} !== exp) begin
      tests_failed++;
      $display("FAIL after_reset_first: got rdy=%b out=%h, want rdy=1 out=%h", sampleReady, outdata, exp[31:0]);
    end
  endtask

  task automatic test_rewrite_mid_count();
    logic [32:0] exp;
    load_divider(24'd2);
    indata = 32'h400; tick();   // sampled, counter 2
    indata = 32'h401; tick();   // counter 1
    load_divider(24'd0);        // input on write cycle dropped
    exp = {1'b0, 32'h400};
    tests_run++;
    if ({sampleReady, outdata} !== exp) begin
      tests_failed++;
      $display("FAIL rewrite_cycle: got rdy=%b out=%h, want rdy=0 out=%h", sampleReady, outdata, exp[31:0]);
    end
    for (int i = 0; i < 3; i++) begin
      indata = 32'h410 + i;
      tick();
      exp = {1'b1, 32'h410 + i};
      tests_run++;
      if ({sampleReady, outdata} !== exp) begin
        tests_failed++;
        $display("FAIL rewrite_after[%0d]: got rdy=%b out=%h, want rdy=1 out=%h", i, sampleReady, outdata, exp[31:0]);
      end
    end
  endtask

  task automatic test_max_divider();
    logic [32:0] exp;
    load_divider(24'hFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      indata = 32'h500 + i;
      tick();
      exp = (i == 0) ? {1'b1, 32'h500} : {1'b0, 32'h500};
      tests_run++;
      if ({sampleReady, outdata} !== exp) begin
        tests_failed++;
        $display("FAIL max_divider[%0d]: got rdy=%b out=%h, want rdy=%b out=%h", i, sampleReady, outdata, exp[32], exp[31:0]);
      end
    end
  endtask

`ifdef SAMPLER_EXTCLK_EN
  task automatic test_ext_clock();
    logic [32:0] exp;
    logic [31:0] held;
    held = 32'h500;
    extClock = 1'b0;
    load_divider(24'd0);
    // Entering external mode suppresses the sample on the switch cycle.
    extClock_mode = 1'b1; indata = 32'h600; tick();
    tests_run++;
    if ({sampleReady, outdata} !== {1'b0, held}) begin
      tests_failed++;
      $display("FAIL ext_mode_switch: got rdy=%b out=%h, want rdy=0 out=%h", sampleReady, outdata, held);
    end
    for (int p = 0; p < 4; p++) begin
      dataReady = (p != 2);
      extClock  = 1'b1;
      for (int c = 0; c < 10; c++) begin
        if (c == 5) extClock = 1'b0;
        indata = 32'h700 + p * 16 + c;
        tick();
        if (c == 2 && dataReady) begin
          held = 32'h700 + p * 16 + c;
          exp  = {1'b1, held};
        end else begin
          exp  = {1'b0, held};
        end
        tests_run++;
        if ({sampleReady, outdata} !== exp) begin
          tests_failed++;
          $display("FAIL ext[%0d.%0d]: got rdy=%b out=%h, want rdy=%b out=%h", p, c, sampleReady, outdata, exp[32], exp[31:0]);
        end
      end
    end
    dataReady = 1'b1; extClock_mode = 1'b0; indata = 32'h800; tick();
    tests_run++;
    if ({sampleReady, outdata} !== {1'b0, held}) begin
      tests_failed++;
      $display("FAIL ext_mode_exit: got rdy=%b out=%h, want rdy=0 out=%h", sampleReady, outdata, held);
    end
    indata = 32'h801; tick();
    tests_run++;
    if ({sampleReady, outdata} !== {1'b1, 32'h801}) begin
      tests_failed++;
      $display("FAIL ext_exit_first: got rdy=%b out=%h, want rdy=1 out=801", sampleReady, outdata);
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0; indata = '0; dataReady = 1'b0;
    wrDivider = 1'b0; config_data = '0;
`ifdef SAMPLER_EXTCLK_EN
    extClock_mode = 1'b0; extClock = 1'b0;
`endif
    #1;
    test_reset();
    test_pass_through();
    test_divide_by_4();
    test_gapped_valid();
    test_reset_mid_count();
    test_rewrite_mid_count();
    test_max_divider();
`ifdef SAMPLER_EXTCLK_EN
    test_ext_clock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
